ultrasonic_distance_ctrl: RTL and testbench

- Drives an HC-SR04-style ultrasonic ranger: issues the trigger pulse, times the echo, and converts echo width to whole centimetres.
- Sits directly upstream of the FND display controller; its `distance` output is the value shown in display mode 010.
- Also flags sensor timeouts so the display path never shows stale-but-fresh-looking data.

---
 rtl/ultrasonic_distance_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ultrasonic_distance_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_distance_ctrl.sv
// HC-SR04 style ranger: trigger, echo timing, cm conversion, timeout flag.
// Define ULTRASONIC_AUTO_EN to free-run measurements without start pulses.
module ultrasonic_distance_ctrl #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int US_PER_CM  = 58,
  parameter int MAX_CM     = 400,
  parameter int TIMEOUT_US = 30_000,
  parameter int COOL_MS    = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       echo,
  output logic       trigger,
  output logic [8:0] distance,
  output logic       dist_valid,
  output logic       busy,
  output logic       err
);

  localparam int DIV     = CLK_FREQ / 1_000_000;
  localparam int COOL_US = COOL_MS * 1000;
  localparam int UMAX0   = (TIMEOUT_US > COOL_US) ? TIMEOUT_US : COOL_US;
  localparam int UMAX    = (UMAX0 > TRIG_US) ? UMAX0 : TRIG_US;
  localparam int UW      = $clog2(UMAX + 1);
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [UW-1:0] TRIG_LAST = UW'(TRIG_US - 1);
  localparam logic [UW-1:0] TO_LAST   = UW'(TIMEOUT_US - 1);
  localparam logic [UW-1:0] COOL_LAST = UW'(COOL_US - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(US_PER_CM - 1);
  localparam logic [8:0]    CM_MAX    = 9'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_DONE,
    S_COOL
  } state_t;

  state_t state, state_n;

  logic [DW-1:0] div_cnt;
  logic          tick_us;
  logic [UW-1:0] us_cnt;
  logic [2:0]    echo_sh;
  logic          echo_rise;
  logic          echo_fall;
  logic [8:0]    cm, cm_nxt;
  logic [SW-1:0] sub, sub_nxt;
  logic          go;
  logic          us_clr;
  logic          meas_clr;
  logic          load_dist;
  logic          set_err;

  assign tick_us   = (div_cnt == DIV_LAST);
  assign echo_rise = echo_sh[1] & ~echo_sh[2];
  assign echo_fall = ~echo_sh[1] & echo_sh[2];

  assign trigger    = (state == S_TRIG);
  assign dist_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);

`ifdef ULTRASONIC_AUTO_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  // free-running microsecond tick divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_cnt <= '0;
    else if (tick_us) div_cnt <= '0;
    else div_cnt <= div_cnt + DW'(1);
  end

  // 2-flop echo synchroniser plus previous sample for edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) echo_sh <= '0;
    else echo_sh <= {echo_sh[1:0], echo};
  end

  // microsecond counter shared by trigger, timeout and cool-down
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) us_cnt <= '0;
    else if (us_clr) us_cnt <= '0;
    else if (tick_us) us_cnt <= us_cnt + UW'(1);
  end

  // next value of the cm/sub pair, including this cycle's tick
  always_comb begin
    sub_nxt = sub;
    cm_nxt  = cm;
    if (tick_us) begin
      if (sub == SUB_LAST) begin
        sub_nxt = '0;
        if (cm != CM_MAX) cm_nxt = cm + 9'd1;
      end else begin
        sub_nxt = sub + SW'(1);
      end
    end
  end

  // echo width accumulators
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cm  <= '0;
      sub <= '0;
    end else if (meas_clr) begin
      cm  <= '0;
      sub <= '0;
    end else if (state == S_MEAS) begin
      cm  <= cm_nxt;
      sub <= sub_nxt;
    end
  end

  // result and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      distance <= '0;
      err      <= 1'b0;
    end else if (load_dist) begin
      distance <= cm_nxt;
      err      <= 1'b0;
    end else if (set_err) begin
      err      <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  end

  // next-state and control strobes
  always_comb begin
    state_n   = state;
    us_clr    = 1'b0;
    meas_clr  = 1'b0;
    load_dist = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          state_n = S_TRIG;
          us_clr  = 1'b1;
        end
      end
      S_TRIG: begin
        if (tick_us && us_cnt == TRIG_LAST) begin
          state_n = S_WAIT;
          us_clr  = 1'b1;
        end
      end
      S_WAIT: begin
        if (echo_rise) begin
          state_n  = S_MEAS;
          us_clr   = 1'b1;
          meas_clr = 1'b1;
        end else if (tick_us && us_cnt == TO_LAST) begin
          state_n = S_COOL;
          us_clr  = 1'b1;
          set_err = 1'b1;
        end
      end
      S_MEAS: begin
        if (echo_fall) begin
          state_n   = S_DONE;
          load_dist = 1'b1;
        end else if (tick_us && us_cnt == TO_LAST) begin
          state_n = S_COOL;
          us_clr  = 1'b1;
          set_err = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_COOL;
        us_clr  = 1'b1;
      end
      S_COOL: begin
        if (tick_us && us_cnt == COOL_LAST) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ultrasonic_distance_ctrl.sv
// Randomised bench for ultrasonic_distance_ctrl against a width/US_PER_CM model.
// Scaled parameters keep every measurement a few thousand cycles long.
module tb_ultrasonic_distance_ctrl;

  localparam int CF   = 2_000_000;
  localparam int DIV  = CF / 1_000_000;
  localparam int TRIG = 10;
  localparam int UPC  = 5;
  localparam int MAXC = 100;
  localparam int TO   = 600;
  localparam int COOL = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       echo = 1'b0;
  logic       trigger;
  logic [8:0] distance;
  logic       dist_valid;
  logic       busy;
  logic       err;

  int n_chk = 0;
  int n_pass = 0;
  int trig_rises = 0;
  logic trig_q = 1'b0;
  int exp_dist = 0;

  always #5 clk = ~clk;

  ultrasonic_distance_ctrl #(
    .CLK_FREQ(CF),
    .TRIG_US(TRIG),
    .US_PER_CM(UPC),
    .MAX_CM(MAXC),
    .TIMEOUT_US(TO),
    .COOL_MS(COOL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .echo(echo),
    .trigger(trigger),
    .distance(distance),
    .dist_valid(dist_valid),
    .busy(busy),
    .err(err)
  );

  always @(negedge clk) begin
    trig_q <= trigger;
    if (trigger && !trig_q) trig_rises <= trig_rises + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model(input int w_us);
    int c;
    c = w_us / UPC;
    return (c > MAXC) ? MAXC : c;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_trig(output int tw);
    for (int i = 0; i < 20 && !trigger; i++) @(negedge clk);
    tw = 0;
    while (trigger && tw < 200) begin
      tw++;
      start = (tw == 5);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n, output int dvc);
    n = 0;
    dvc = 0;
    while (busy && n < 8000) begin
      if (dist_valid) dvc++;
      start = (n == 100);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) chk("busy_stuck", 1, 0);
  endtask

  task automatic do_meas(input int d, input int w);
    int tw, lat, n, dvc, tr0;
    tr0 = trig_rises;
    pulse_start();
    wait_trig(tw);
    chk("trig_width", int'(tw >= (TRIG - 1) * DIV + 1 && tw <= TRIG * DIV), 1);
    repeat (d * DIV) @(negedge clk);
    echo = 1'b1;
    for (int i = 0; i < w * DIV; i++) begin
      start = (i == 5);
      @(negedge clk);
    end
    echo = 1'b0;
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dist_valid && lat < 10);
    exp_dist = model(w);
    chk("valid_lat", lat, 3);
    chk("distance", int'(distance), exp_dist);
    chk("err_clear", int'(err), 0);
    wait_idle(n, dvc);
    chk("dv_once", dvc, 1);
    chk("cool_len", int'(n >= COOL * 1000 * DIV - 1 && n <= COOL * 1000 * DIV + 2), 1);
    chk("one_trig", trig_rises - tr0, 1);
  endtask

  task automatic do_timeout(input bit stuck);
    int tw, n, dvc, dv0, tr0;
    tr0 = trig_rises;
    dv0 = 0;
    pulse_start();
    wait_trig(tw);
    if (stuck) begin
      repeat (20 * DIV) @(negedge clk);
      echo = 1'b1;
    end
    n = 0;
    while (!err && n < 4000) begin
      if (dist_valid) dv0++;
      @(negedge clk);
      n++;
    end
    chk("err_set", int'(err), 1);
    if (!stuck)
      chk("wait_to_len", int'(n >= TO * DIV - 3 && n <= TO * DIV + 3), 1);
    repeat (100 * DIV) @(negedge clk);
    echo = 1'b0;
    wait_idle(n, dvc);
    chk("to_no_dv", dv0 + dvc, 0);
    chk("to_dist_kept", int'(distance), exp_dist);
    chk("err_sticky", int'(err), 1);
    chk("to_one_trig", trig_rises - tr0, 1);
  endtask

  initial begin
    reset = 1'b0;
    echo  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_distance", int'(distance), 0);
    chk("rst_valid", int'(dist_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b1;
    echo  = 1'b0;
`ifdef ULTRASONIC_AUTO_EN
    repeat (8000) @(negedge clk);
    chk("auto_retrig", int'(trig_rises >= 2), 1);
`else
    repeat (1000 * DIV) @(negedge clk);
    chk("idle_no_trig", trig_rises, 0);
    chk("idle_busy", int'(busy), 0);

    do_meas(100, 50);
    do_meas(37, 53);
    do_meas(20, 590);
    do_meas(5, 4);
    do_meas(12, 50);
    do_timeout(1'b0);
    do_meas(30, 100);
    do_timeout(1'b1);

    for (int k = 0; k < 6; k++)
      do_meas(int'($urandom_range(1, 250)), int'($urandom_range(1, 595)));

    pulse_start();
    begin
      int tw;
      wait_trig(tw);
    end
    repeat (10) @(negedge clk);
    echo = 1'b1;
    repeat (40) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_trigger", int'(trigger), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_distance", int'(distance), 0);
    chk("mid_rst_err", int'(err), 0);
    exp_dist = 0;
    @(negedge clk);
    echo = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("rst_no_retrig", int'(busy), 0);
    do_meas(15, 77);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
